// File: rtl/cluster_periph_demux_pkg.sv
// Cluster peripheral plug map shared by the periph demux and its FIFO entry type.
// Holds the plug count, the SPER_*_ID plug indices, the address field that selects a plug,
// and the in-order response FIFO entry layout.
package pulp_cluster_package;

  localparam int NB_SPERIPHS  = 11;
  localparam int PER_ID_WIDTH = 5;

  localparam int SPER_IDX_LSB = 10;
  localparam int SPER_IDX_MSB = 13;

  localparam logic [3:0] SPER_EOC_ID         = 4'd0;
  localparam logic [3:0] SPER_TIMER_ID       = 4'd1;
  localparam logic [3:0] SPER_EVENT_U_ID     = 4'd2;
  // Index 3 has no plug behind it; it decodes as unmapped.
  localparam logic [3:0] SPER_HOLE_ID        = 4'd3;
  localparam logic [3:0] SPER_HWPE_ID        = 4'd4;
  localparam logic [3:0] SPER_ICACHE_CTRL_ID = 4'd5;
  localparam logic [3:0] SPER_DMA_CL_ID      = 4'd6;
  localparam logic [3:0] SPER_DMA_FC_ID      = 4'd7;
  localparam logic [3:0] SPER_DECOMP_ID      = 4'd8;
  localparam logic [3:0] SPER_LOCKSTEP_ID    = 4'd9;
  localparam logic [3:0] SPER_EXT_ID         = 4'd10;

  // One outstanding transaction: internal-error token, its ID, and the plug it went to.
  typedef struct packed {
    logic                    err;
    logic [PER_ID_WIDTH-1:0] id;
    logic [3:0]              idx;
  } per_fifo_entry_t;

  function automatic logic sper_idx_mapped(input logic [3:0] idx);
    return (int'(idx) < NB_SPERIPHS) && (idx != SPER_HOLE_ID);
  endfunction

endpackage

// File: rtl/cluster_periph_demux_if.sv
// Cluster peripheral master port: request (req/gnt, address, data, BE, ID) and in-order response.
// master modport = the periph interconnect side; slave modport = the demux side.
// Ports: req, gnt, add, wen (1 = read), wdata, be, id, r_valid, r_rdata, r_opc (error), r_id.
interface cluster_periph_demux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 5
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ID_WIDTH-1:0]     id;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_opc;
  logic [ID_WIDTH-1:0]     r_id;

  modport master (
    output req, add, wen, wdata, be, id,
    input  gnt, r_valid, r_rdata, r_opc, r_id
  );

  modport slave (
    input  req, add, wen, wdata, be, id,
    output gnt, r_valid, r_rdata, r_opc, r_id
  );
endinterface

// File: rtl/cluster_periph_resp_fifo.sv
// In-order FIFO of outstanding periph targets; head is visible combinationally.
// Ports: clk_i, rst_ni (async, active-low), push_i/data_i, pop_i, head_o, full_o, empty_o.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module cluster_periph_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_i)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: an entry is only read once the pointers say it was written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  assign head_o  = mem[rd_ptr[AW-1:0]];
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cluster_periph_demux.sv
// Routes the cluster periph master port to NB_SPERIPHS plugs by add[13:10]; responses return in order.
// Ports: clk_i, rst_ni (async, active-low), mst (slave modport of the master port), per_* plug-side
// request/grant, broadcast request fields and per-plug responses. Request and response paths add 0 cycles.
// Optional: CLUSTER_PERIPH_DEMUX_ERR_RESP_EN answers unmapped addresses internally with an error response.
module cluster_periph_demux
  import pulp_cluster_package::*;
#(
  parameter int NB_SPERIPHS  = pulp_cluster_package::NB_SPERIPHS,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = PER_ID_WIDTH,
  parameter int MAX_OUTSTAND = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  cluster_periph_demux_if.slave   mst,

  output logic [NB_SPERIPHS-1:0]  per_req_o,
  input  logic [NB_SPERIPHS-1:0]  per_gnt_i,
  output logic [ADDR_WIDTH-1:0]   per_add_o,
  output logic                    per_wen_o,
  output logic [DATA_WIDTH-1:0]   per_wdata_o,
  output logic [DATA_WIDTH/8-1:0] per_be_o,
  output logic [ID_WIDTH-1:0]     per_id_o,

  input  logic [NB_SPERIPHS-1:0]  per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   per_r_rdata_i [NB_SPERIPHS],
  input  logic [NB_SPERIPHS-1:0]  per_r_opc_i,
  input  logic [ID_WIDTH-1:0]     per_r_id_i    [NB_SPERIPHS]
);

  localparam int EW = $bits(per_fifo_entry_t);

  logic [3:0]            idx;
  logic                  mapped;
  logic [3:0]            tgt;
  logic                  err_req;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  per_fifo_entry_t       push_entry;
  per_fifo_entry_t       head;
  logic                  plug_vld;
  logic                  err_vld;
  logic [NB_SPERIPHS-1:0] head_mask;

  // ---------------- decode ----------------
  assign idx    = mst.add[SPER_IDX_MSB:SPER_IDX_LSB];
  assign mapped = sper_idx_mapped(idx);
  // Unmapped addresses fall through to the external plug; with the error responder
  // they never reach a plug, so the EXT index stored with them is just a safe filler.
  assign tgt    = mapped ? idx : SPER_EXT_ID;

`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5);
  assign err_req = ~mapped;
`else
  assign err_req = 1'b0;
`endif

  // ---------------- request path ----------------
  assign per_add_o   = mst.add;
  assign per_wen_o   = mst.wen;
  assign per_wdata_o = mst.wdata;
  assign per_be_o    = mst.be;
  assign per_id_o    = mst.id;

  // A full FIFO blocks new requests outright, even if the head pops this cycle.
  // rst_ni gates the handshake so every master/plug-facing control output drops with reset.
  always_comb begin
    per_req_o = '0;
    if (rst_ni && mst.req && !fifo_full && !err_req) per_req_o[tgt] = 1'b1;
  end

  assign mst.gnt = rst_ni & ~fifo_full & (err_req | per_gnt_i[tgt]);
  assign push    = mst.req & mst.gnt;

  assign push_entry.err = err_req;
  assign push_entry.id  = mst.id;
  assign push_entry.idx = tgt;

  cluster_periph_resp_fifo #(
    .DEPTH (MAX_OUTSTAND),
    .WIDTH (EW)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- response path ----------------
  // Only the plug at the FIFO head may answer; anything else is dropped here.
  assign plug_vld = ~fifo_empty & ~head.err & per_r_valid_i[head.idx];

`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
  // An error token answers as soon as it is visible at head, i.e. at the earliest
  // the cycle after its handshake.
  assign err_vld = ~fifo_empty & head.err;
`else
  assign err_vld = 1'b0;
  logic unused_head;
  assign unused_head = ^{head.err, head.id};
`endif

  assign pop         = plug_vld | err_vld;
  assign mst.r_valid = pop;

  always_comb begin
    mst.r_rdata = '0;
    mst.r_opc   = 1'b0;
    mst.r_id    = '0;
    if (plug_vld) begin
      mst.r_rdata = per_r_rdata_i[head.idx];
      mst.r_opc   = per_r_opc_i[head.idx];
      mst.r_id    = per_r_id_i[head.idx];
    end
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    else if (err_vld) begin
      mst.r_rdata = ERR_RDATA;
      mst.r_opc   = 1'b1;
      mst.r_id    = head.id;
    end
`endif
  end

  // ---------------- protocol check ----------------
  always_comb begin
    head_mask = '0;
    if (!fifo_empty && !head.err) head_mask[head.idx] = 1'b1;
  end

  a_rvalid_from_head : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (per_r_valid_i & ~head_mask) == '0
  ) else $error("cluster_periph_demux: r_valid from a plug that is not at head (%b)", per_r_valid_i);

endmodule

// File: tb/tb_cluster_periph_demux.sv
module tb_cluster_periph_demux;

  localparam int NP = 11;

  typedef struct {
    logic [31:0] data;
    logic        opc;
    logic [4:0]  id;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] per_req;
  logic [NP-1:0] per_gnt;
  logic [31:0]   per_add;
  logic          per_wen;
  logic [31:0]   per_wdata;
  logic [3:0]    per_be;
  logic [4:0]    per_id;
  logic [NP-1:0] per_r_valid;
  logic [31:0]   per_r_rdata [NP];
  logic [NP-1:0] per_r_opc;
  logic [4:0]    per_r_id    [NP];

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 clk = ~clk;

  cluster_periph_demux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(5)) bus ();

  cluster_periph_demux dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mst           (bus),
    .per_req_o     (per_req),
    .per_gnt_i     (per_gnt),
    .per_add_o     (per_add),
    .per_wen_o     (per_wen),
    .per_wdata_o   (per_wdata),
    .per_be_o      (per_be),
    .per_id_o      (per_id),
    .per_r_valid_i (per_r_valid),
    .per_r_rdata_i (per_r_rdata),
    .per_r_opc_i   (per_r_opc),
    .per_r_id_i    (per_r_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data a well-behaved plug returns for a given transaction.
  function automatic logic [31:0] pdata(input int p, input logic [4:0] id);
    return 32'hA500_0000 | (32'(p) << 8) | {27'b0, id};
  endfunction

  task automatic expect_rsp(input int p, input logic [4:0] id);
    rsp_t e;
    e.data = pdata(p, id);
    e.opc  = id[0];
    e.id   = id;
    exp_q.push_back(e);
  endtask

  // Advance one cycle; inputs change 2ns after the edge and default to idle.
  task automatic cyc();
    @(posedge clk);
    #2;
    bus.req     = 1'b0;
    per_gnt     = '0;
    per_r_valid = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [4:0] i);
    bus.req   = 1'b1;
    bus.add   = a;
    bus.wen   = w;
    bus.wdata = 32'hC0DE_0000 | {27'b0, i};
    bus.be    = 4'hF;
    bus.id    = i;
  endtask

  task automatic plug_rsp(input int p, input logic [4:0] id);
    per_r_valid[p] = 1'b1;
    per_r_rdata[p] = pdata(p, id);
    per_r_opc[p]   = id[0];
    per_r_id[p]    = id;
  endtask

  // Scoreboard: every forwarded response must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.r_valid) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL rsp_unexpected: observed r_valid id %0h expected no response", bus.r_id);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", bus.r_rdata, mon_e.data);
        chk("rsp_opc",   bus.r_opc,   mon_e.opc);
        chk("rsp_id",    bus.r_id,    mon_e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      per_r_rdata[p] = 32'hFFFF_FFFF;
      per_r_id[p]    = 5'h1F;
    end
    per_r_opc = '1;
    // Busy-looking inputs during reset: every output must still read 0.
    req(32'h1020_0400, 1'b0, 5'h1F);
    per_gnt     = '1;
    per_r_valid = '1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_gnt",     bus.gnt,     1'b0);
    chk("rst_per_req", per_req,     11'h000);
    chk("rst_r_valid", bus.r_valid, 1'b0);
    chk("rst_r_rdata", bus.r_rdata, 32'h0);
    chk("rst_r_opc",   bus.r_opc,   1'b0);
    chk("rst_r_id",    bus.r_id,    5'h0);
    cyc();
    rst_n = 1'b1;

    // Write to TIMER, immediate grant, response one cycle later.
    cyc();
    req(32'h1020_0400, 1'b0, 5'd3);
    per_gnt[1] = 1'b1;
    expect_rsp(1, 5'd3);
    #1;
    chk("t1_per_req", per_req, 11'h002);
    chk("t1_gnt",     bus.gnt, 1'b1);
    chk("t1_per_add", per_add, 32'h1020_0400);
    chk("t1_per_wen", per_wen, 1'b0);
    chk("t1_per_id",  per_id,  5'd3);
    cyc();
    plug_rsp(1, 5'd3);
    #1;
    chk("t1_r_valid", bus.r_valid, 1'b1);
    chk("t1_r_id",    bus.r_id,    5'd3);
    cyc();
    #1;
    chk("t1_idle", bus.r_valid, 1'b0);

    // Four reads to DMA_CL fill the FIFO; the fifth waits for a pop.
    for (int k = 0; k < 4; k++) begin
      cyc();
      req(32'h1020_1800, 1'b1, 5'(8 + k));
      per_gnt[6] = 1'b1;
      expect_rsp(6, 5'(8 + k));
      #1;
      chk("t2_gnt", bus.gnt, 1'b1);
    end
    cyc();
    req(32'h1020_1800, 1'b1, 5'd12);
    per_gnt[6] = 1'b1;
    #1;
    chk("t2_full_gnt", bus.gnt, 1'b0);
    chk("t2_full_req", per_req, 11'h000);
    cyc();
    req(32'h1020_1800, 1'b1, 5'd12);
    per_gnt[6] = 1'b1;
    plug_rsp(6, 5'd8);
    #1;
    chk("t2_nobypass_gnt", bus.gnt,     1'b0);
    chk("t2_pop_valid",    bus.r_valid, 1'b1);
    cyc();
    req(32'h1020_1800, 1'b1, 5'd12);
    per_gnt[6] = 1'b1;
    expect_rsp(6, 5'd12);
    #1;
    chk("t2_regrant_gnt", bus.gnt, 1'b1);
    chk("t2_regrant_req", per_req, 11'h040);
    for (int k = 9; k <= 12; k++) begin
      cyc();
      plug_rsp(6, 5'(k));
      #1;
      chk("t2_drain_valid", bus.r_valid, 1'b1);
    end

    // EOC (3-cycle latency) then TIMER: TIMER waits until EOC has popped.
    cyc();
    req(32'h1020_0000, 1'b1, 5'd1);
    per_gnt[0] = 1'b1;
    expect_rsp(0, 5'd1);
    #1;
    chk("t3_eoc_gnt", bus.gnt, 1'b1);
    cyc();
    req(32'h1020_0400, 1'b1, 5'd2);
    per_gnt[1] = 1'b1;
    expect_rsp(1, 5'd2);
    #1;
    chk("t3_timer_gnt", bus.gnt,     1'b1);
    chk("t3_wait1",     bus.r_valid, 1'b0);
    cyc();
    #1;
    chk("t3_wait2", bus.r_valid, 1'b0);
    cyc();
    plug_rsp(0, 5'd1);
    #1;
    chk("t3_eoc_id", bus.r_id, 5'd1);
    cyc();
    plug_rsp(1, 5'd2);
    #1;
    chk("t3_timer_id", bus.r_id, 5'd2);

    // Unmapped index 3.
    cyc();
    req(32'h1020_0C00, 1'b1, 5'd7);
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    per_gnt = '1;
    #1;
    chk("t4_err_req", per_req, 11'h000);
    chk("t4_err_gnt", bus.gnt, 1'b1);
    exp_q.push_back('{data: 32'hBADACCE5, opc: 1'b1, id: 5'd7});
    cyc();
    #1;
    chk("t4_err_valid", bus.r_valid, 1'b1);
    chk("t4_err_opc",   bus.r_opc,   1'b1);
    chk("t4_err_rdata", bus.r_rdata, 32'hBADACCE5);
`else
    per_gnt[10] = 1'b1;
    expect_rsp(10, 5'd7);
    #1;
    chk("t4_ext_req", per_req, 11'h400);
    chk("t4_ext_gnt", bus.gnt, 1'b1);
    cyc();
    plug_rsp(10, 5'd7);
    #1;
    chk("t4_ext_valid", bus.r_valid, 1'b1);
`endif

    // Reset with two outstanding: outputs drop at once, late responses are dropped.
    cyc();
    req(32'h1020_1800, 1'b1, 5'd20);
    per_gnt[6] = 1'b1;
    cyc();
    req(32'h1020_1800, 1'b1, 5'd21);
    per_gnt[6] = 1'b1;
    cyc();
    req(32'h1020_1800, 1'b1, 5'd22);
    per_gnt[6] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", bus.gnt, 1'b0);
    chk("t5_async_req", per_req, 11'h000);
    cyc();
    plug_rsp(6, 5'd20);
    #1;
    chk("t5_drop_valid", bus.r_valid, 1'b0);
    chk("t5_drop_rdata", bus.r_rdata, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    req(32'h1020_0400, 1'b1, 5'd23);
    per_gnt[1] = 1'b1;
    expect_rsp(1, 5'd23);
    #1;
    chk("t5_post_gnt", bus.gnt, 1'b1);
    cyc();
    plug_rsp(1, 5'd23);
    #1;
    chk("t5_post_id", bus.r_id, 5'd23);

    // Push and pop together at count MAX_OUTSTAND-1 across several pointer wraps.
    for (int k = 0; k < 3; k++) begin
      cyc();
      req(32'h1020_0800, 1'b1, 5'(k));
      per_gnt[2] = 1'b1;
      expect_rsp(2, 5'(k));
    end
    for (int k = 0; k < 20; k++) begin
      cyc();
      req(32'h1020_0800, 1'b1, 5'(k + 3));
      per_gnt[2] = 1'b1;
      plug_rsp(2, 5'(k));
      expect_rsp(2, 5'(k + 3));
      #1;
      chk("t6_steady_gnt", bus.gnt, 1'b1);
    end
    for (int k = 20; k < 23; k++) begin
      cyc();
      plug_rsp(2, 5'(k));
    end
    cyc();
    #1;
    chk("end_idle_valid", bus.r_valid, 1'b0);
    @(negedge clk);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
